// File: rtl/noc_pkg.sv
// Shared NoC register-request definitions: packet field positions, node geometry
// and the responder FSM state encoding.
package noc_pkg;

  localparam int VALID_BIT     = 0;
  localparam int DEST_LSB      = 1;
  localparam int SRC_LSB       = 3;
  localparam int REGID_LSB     = 5;
  localparam int NODE_W        = 2;
  localparam int REGID_W       = 6;
  localparam int REGS_PER_NODE = 16;
  localparam int NUM_NODES     = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    SEND   = 2'd2
  } state_t;

endpackage

// File: rtl/reg_responder_if.sv
// NoC-side bundle of the register responder: show-ahead ejection FIFO plus the
// write/full/almost_full injection port. The responder uses the slave modport.
interface reg_responder_if #(
  parameter int REQ_W  = 11,
  parameter int RESP_W = 27
) ();

  logic [REQ_W-1:0]  dataIn;
  logic              empty;
  logic              read;
  logic [RESP_W-1:0] dataOut;
  logic              write;
  logic              full;
  logic              almost_full;

  modport master (
    output dataIn, empty, full, almost_full,
    input  read, dataOut, write
  );

  modport slave (
    input  dataIn, empty, full, almost_full,
    output read, dataOut, write
  );

endinterface

// File: rtl/reg_responder_reg_bank.sv
// Local 16-entry register bank: one write port, one registered read port.
// A read and a write to the same entry on the same edge return the old value.
module reg_bank
  import noc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [3:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [REGS_PER_NODE];

  // rd_data only moves on a lookup, so it stays stable while a response waits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REGS_PER_NODE; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/reg_responder.sv
// Destination endpoint for register requests: queues requests for this node,
// reads the local bank and injects responses. Optional stats: RESPONDER_STATS_EN.
module reg_responder
  import noc_pkg::*;
#(
  parameter int REQ_W  = 11,
  parameter int DATA_W = 16,
  parameter int QDEPTH = 4,
  parameter int RESP_W = DATA_W + 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        id,
  reg_responder_if.slave    noc,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data
`ifdef RESPONDER_STATS_EN
  ,
  output logic [15:0]       served_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [REGID_W-1:0] regid_q [QDEPTH];
  logic [NODE_W-1:0]  src_q   [QDEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;

  logic [REGID_W-1:0] in_regid;
  logic [NODE_W-1:0]  in_src, in_dest;
  logic               read_int, accept, q_full, inject, send_ok;
  logic               bank_rd_en;
  logic [DATA_W-1:0]  bank_rd_data;
  logic [RESP_W-1:0]  data_out_r;
  logic               write_r;
  state_t             state, next_state;

  assign in_regid = noc.dataIn[REGID_LSB +: REGID_W];
  assign in_src   = noc.dataIn[SRC_LSB +: NODE_W];
  assign in_dest  = noc.dataIn[DEST_LSB +: NODE_W];

  // Reset gates read so a pop can never slip through while the queue is discarded
  assign q_full   = (count == CW'(QDEPTH));
  assign read_int = reset & ~noc.empty & ~q_full;
  assign accept   = read_int & noc.dataIn[VALID_BIT] & (in_dest == id)
                  & (in_regid[REGID_W-1 -: NODE_W] == id);

  assign send_ok = (write_r & ~noc.almost_full) | (~write_r & ~noc.full);
  assign inject  = (state == SEND) & send_ok;

  assign noc.read    = read_int;
  assign noc.write   = write_r;
  assign noc.dataOut = data_out_r;

  always_ff @(posedge clk) begin
    if (accept) begin
      regid_q[wr_ptr] <= in_regid;
      src_q[wr_ptr]   <= in_src;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (inject) rd_ptr <= rd_ptr + 1'b1;
      if (accept && !inject)      count <= count + CW'(1);
      else if (!accept && inject) count <= count - CW'(1);
    end
  end

  reg_bank #(.DATA_W(DATA_W)) u_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (bank_rd_en),
    .rd_addr (regid_q[rd_ptr][3:0]),
    .rd_data (bank_rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // After an injection the head is gone; a simultaneous push also keeps us busy
  always_comb begin
    next_state = state;
    bank_rd_en = 1'b0;
    case (state)
      IDLE:    if (count != '0) next_state = LOOKUP;
      LOOKUP: begin
        bank_rd_en = 1'b1;
        next_state = SEND;
      end
      SEND:    if (inject) next_state = (count > CW'(1) || accept) ? LOOKUP : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_r    <= 1'b0;
      data_out_r <= '0;
    end else begin
      write_r <= inject;
      if (state == SEND)
        data_out_r <= {bank_rd_data, regid_q[rd_ptr], id, src_q[rd_ptr], 1'b1};
    end
  end

`ifdef RESPONDER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      served_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (inject && served_cnt != 16'hFFFF) served_cnt <= served_cnt + 16'd1;
      if (read_int && !accept && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_responder.sv
// Self-checking bench for reg_responder: ejection FIFO and register bank are
// modelled as queues/arrays, and every response is matched in FIFO order.
module tb_reg_responder;
  import noc_pkg::*;

  localparam int REQ_W  = 11;
  localparam int DATA_W = 16;
  localparam int QDEPTH = 4;
  localparam int RESP_W = DATA_W + 11;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        id;
  logic              wr_en;
  logic [3:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
`ifdef RESPONDER_STATS_EN
  logic [15:0]       served_cnt, drop_cnt;
`endif

  reg_responder_if #(.REQ_W(REQ_W), .RESP_W(RESP_W)) noc ();

  reg_responder #(.REQ_W(REQ_W), .DATA_W(DATA_W), .QDEPTH(QDEPTH), .RESP_W(RESP_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .id      (id),
    .noc     (noc),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
`ifdef RESPONDER_STATS_EN
    ,
    .served_cnt (served_cnt),
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] bank_m [16];
  logic [RESP_W-1:0] exp_q [$];
  logic [REQ_W-1:0]  pkt_q [$];
  int occ, pops, served_m, drops_m, writes_total, edge_cnt;
  int last_pop_edge, last_write_edge;
  logic [RESP_W-1:0] last_resp;
  int pass_cnt = 0;
  int check_cnt = 0;

  logic s_reset, s_read, s_empty, s_wr_en, s_write, s_full, s_af;
  logic [REQ_W-1:0]  s_din;
  logic [3:0]        s_wr_addr;
  logic [DATA_W-1:0] s_wr_data;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic setFifo();
    noc.empty  = (pkt_q.size() == 0);
    noc.dataIn = (pkt_q.size() != 0) ? pkt_q[0] : '0;
  endtask

  task automatic resetModel();
    exp_q.delete();
    pkt_q.delete();
    occ = 0;
    served_m = 0;
    drops_m = 0;
    for (int i = 0; i < 16; i++) bank_m[i] = '0;
    setFifo();
  endtask

  // One clock: check read before the edge, advance the model on the edge,
  // then check any injected response just after it.
  task automatic applyStimulus();
    @(negedge clk);
    s_reset = reset; s_read = noc.read; s_empty = noc.empty; s_din = noc.dataIn;
    s_wr_en = wr_en; s_wr_addr = wr_addr; s_wr_data = wr_data;
    s_write = noc.write; s_full = noc.full; s_af = noc.almost_full;
    if (s_reset) checkOutput("read", 64'(s_read), 64'(!s_empty && occ < QDEPTH));
    else         checkOutput("read_in_reset", 64'(s_read), 64'(0));
    @(posedge clk);
    #1;
    edge_cnt++;
    if (s_reset) begin
      if (s_wr_en) bank_m[s_wr_addr] = s_wr_data;
      if (s_read && pkt_q.size() != 0) begin
        void'(pkt_q.pop_front());
        pops++;
        last_pop_edge = edge_cnt;
        if (s_din[0] && s_din[2:1] == id && s_din[10:9] == id) begin
          exp_q.push_back({bank_m[s_din[8:5]], s_din[10:5], id, s_din[4:3], 1'b1});
          occ++;
        end else begin
          drops_m++;
        end
      end
    end
    if (!reset) begin
      checkOutput("write_in_reset", 64'(noc.write), 64'(0));
    end else if (noc.write) begin
      writes_total++;
      last_resp = noc.dataOut;
      last_write_edge = edge_cnt;
      checkOutput("write_pulse", 64'(s_write), 64'(0));
      checkOutput("inject_allowed", 64'(s_write ? !s_af : !s_full), 64'(1));
      if (exp_q.size() == 0) begin
        checkOutput("spurious_write", 64'(1), 64'(0));
      end else begin
        checkOutput("dataOut", 64'(noc.dataOut), 64'(exp_q.pop_front()));
        occ--;
        served_m++;
      end
    end
`ifdef RESPONDER_STATS_EN
    checkOutput("served_cnt", 64'(served_cnt), 64'(served_m));
    checkOutput("drop_cnt", 64'(drop_cnt), 64'(drops_m));
`endif
    setFifo();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic waitWrite(input int limit);
    int w0 = writes_total;
    int n = 0;
    while (writes_total == w0 && n < limit) begin
      applyStimulus();
      n++;
    end
    if (writes_total == w0) checkOutput("write_timeout", 64'(1), 64'(0));
  endtask

  task automatic drain(input string name, input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || pkt_q.size() != 0) && n < limit) begin
      applyStimulus();
      n++;
    end
    checkOutput(name, 64'(exp_q.size() + pkt_q.size()), 64'(0));
  endtask

  function automatic logic [REQ_W-1:0] mkPkt(input int regid, input int src, input int dest);
    logic [5:0] r = 6'(regid);
    logic [1:0] s = 2'(src);
    logic [1:0] d = 2'(dest);
    return {r, s, d, 1'b1};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p0, s0;
    logic [5:0] rg;
    logic [1:0] dst;
    reset = 1'b0; id = 2'd2; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    noc.full = 1'b0; noc.almost_full = 1'b0;
    occ = 0; pops = 0; served_m = 0; drops_m = 0; writes_total = 0; edge_cnt = 0;
    last_pop_edge = 0; last_write_edge = 0; last_resp = '0;
    resetModel();

    runCycles(2);
    checkOutput("dataOut_reset", 64'(noc.dataOut), 64'(0));
    reset = 1'b1;

    // Minimum-latency lookup of regid 37 from node 1
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234;
    applyStimulus();
    wr_en = 1'b0;
    pkt_q.push_back(11'b100101_01_10_1);
    setFifo();
    waitWrite(20);
    checkOutput("latency_edges", 64'(last_write_edge - last_pop_edge), 64'(3));
    checkOutput("latency_data", 64'(last_resp), 64'({16'h1234, 6'd37, 2'd2, 2'd1, 1'b1}));

    // Packets for another node or another node's register range are dropped
    p0 = pops;
    pkt_q.push_back(mkPkt(37, 1, 3));
    pkt_q.push_back(mkPkt(5, 1, 2));
    setFifo();
    runCycles(10);
    checkOutput("drop_pops", 64'(pops - p0), 64'(2));
    checkOutput("drop_model", 64'(drops_m), 64'(2));

    // Backpressure: the queue absorbs four requests and the rest wait upstream
    noc.full = 1'b1;
    p0 = pops; s0 = served_m;
    for (int i = 0; i < 6; i++) pkt_q.push_back(mkPkt(32 + i, i % 4, 2));
    setFifo();
    runCycles(10);
    checkOutput("full_pops", 64'(pops - p0), 64'(4));
    checkOutput("full_read", 64'(noc.read), 64'(0));
    checkOutput("full_left_upstream", 64'(pkt_q.size()), 64'(2));
    noc.full = 1'b0;
    drain("full_drain", 100);
    checkOutput("full_none_lost", 64'(served_m - s0), 64'(6));

    // almost_full during a burst
    noc.almost_full = 1'b1;
    for (int i = 0; i < 4; i++) pkt_q.push_back(mkPkt(40 + i, 3, 2));
    setFifo();
    runCycles(6);
    noc.almost_full = 1'b0;
    drain("af_drain", 60);

    // Local write colliding with the lookup of the same entry
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h00AA;
    applyStimulus();
    wr_en = 1'b0;
    p0 = pops;
    pkt_q.push_back(mkPkt(35, 0, 2));
    setFifo();
    for (int n = 0; n < 10 && pops == p0; n++) applyStimulus();
    applyStimulus();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF;
    applyStimulus();
    wr_en = 1'b0;
    waitWrite(10);
    checkOutput("collision_old", 64'(last_resp[RESP_W-1:11]), 64'(16'h00AA));
    pkt_q.push_back(mkPkt(35, 1, 2));
    setFifo();
    waitWrite(20);
    checkOutput("collision_new", 64'(last_resp[RESP_W-1:11]), 64'(16'hBEEF));

    // Asynchronous reset right after an injection with requests still queued
    noc.full = 1'b1;
    for (int i = 0; i < 3; i++) pkt_q.push_back(mkPkt(44 + i, i, 2));
    setFifo();
    runCycles(6);
    noc.full = 1'b0;
    waitWrite(10);
    pkt_q.push_back(mkPkt(47, 2, 2));
    setFifo();
    #2;
    reset = 1'b0;
    #1;
    checkOutput("reset_write", 64'(noc.write), 64'(0));
    checkOutput("reset_read", 64'(noc.read), 64'(0));
    resetModel();
    runCycles(2);
    reset = 1'b1;
    runCycles(10);
    checkOutput("reset_quiet", 64'(served_m), 64'(0));
    pkt_q.push_back(mkPkt(38, 3, 2));
    setFifo();
    waitWrite(20);
    checkOutput("reset_bank_cleared", 64'(last_resp), 64'({16'h0000, 6'd38, 2'd2, 2'd3, 1'b1}));

    // Randomized traffic with random backpressure as node 1
    id = 2'd1;
    for (int a = 0; a < 16; a++) begin
      wr_en = 1'b1; wr_addr = 4'(a); wr_data = 16'($urandom);
      applyStimulus();
    end
    wr_en = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        rg[3:0] = 4'($urandom_range(0, 15));
        rg[5:4] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : id;
        dst     = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : id;
        pkt_q.push_back({rg, 2'($urandom_range(0, 3)), dst, ($urandom_range(0, 9) != 0)});
        setFifo();
      end
      noc.full        = ($urandom_range(0, 3) == 0);
      noc.almost_full = ($urandom_range(0, 2) == 0);
      applyStimulus();
    end
    noc.full = 1'b0; noc.almost_full = 1'b0;
    drain("random_drain", 300);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
